// File: rtl/burst_mem_pkg.sv
// Shared types and constants for the burst physical-memory responder.
package burst_mem_pkg;

  localparam int BEATS      = 4;
  localparam int BEAT_W     = 64;
  localparam int LINE_BYTES = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } bm_state_e;

endpackage

// File: rtl/burst_mem_array.sv
// Single-port line store: DEPTH_LINES*4 words of 64 bits, one access per cycle,
// registered read data that holds its value when no read is issued.
module burst_mem_array
  import burst_mem_pkg::*;
#(
  parameter int DEPTH_LINES = 1024,
  localparam int AW = $clog2(DEPTH_LINES) + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [BEAT_W-1:0] wdata,
  output logic [BEAT_W-1:0] rdata
);

  logic [BEAT_W-1:0] mem [DEPTH_LINES*BEATS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // The read register doubles as the port's output register, so it is cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/burst_mem_responder.sv
// Cycle-accurate backing memory for the 4-beat pmem line port with a fixed access latency.
// Optional build macro BURST_MEM_ADDR_CHECK_EN adds the pmem_err protocol-check output.
module burst_mem_responder
  import burst_mem_pkg::*;
#(
  parameter int LATENCY     = 10,
  parameter int DEPTH_LINES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [31:0]       pmem_address,
  input  logic [BEAT_W-1:0] pmem_wdata,
  output logic [BEAT_W-1:0] pmem_rdata,
  output logic              pmem_resp
`ifdef BURST_MEM_ADDR_CHECK_EN
  ,
  output logic              pmem_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam int AW    = IDX_W + 2;
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  bm_state_e        state, state_nxt;
  logic [LAT_W-1:0] lat_cnt;
  logic [1:0]       beat_cnt;
  logic             req_rd_p0;
  logic [IDX_W-1:0] req_line_p0;

  logic             accept;
  logic             lat_last;
  logic [IDX_W-1:0] addr_line;
  logic             mem_re;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;

  assign accept    = (state == IDLE) && (pmem_read || pmem_write);
  assign lat_last  = (lat_cnt == LAT_LAST);
  assign addr_line = pmem_address[5 +: IDX_W];

  // Address bits above the line index and the byte offset never reach the array.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{pmem_address[31:5+IDX_W], pmem_address[4:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (LATENCY == 0) ? BURST : WAIT;
      WAIT:    if (lat_last) state_nxt = BURST;
      BURST:   if (beat_cnt == 2'd3) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt  <= '0;
      beat_cnt <= '0;
    end else begin
      lat_cnt  <= (state == WAIT && !lat_last) ? lat_cnt + 1'b1 : '0;
      beat_cnt <= (state == BURST) ? beat_cnt + 2'd1 : 2'd0;
    end
  end

  // Request capture: read wins when both request lines are high.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_rd_p0   <= pmem_read;
      req_line_p0 <= addr_line;
    end
  end

  // Reads are issued a cycle ahead of their beat so pmem_rdata comes straight from a register.
  always_comb begin
    pmem_resp = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    case (state)
      IDLE: begin
        if (accept && LATENCY == 0 && pmem_read) begin
          mem_re   = 1'b1;
          mem_addr = {addr_line, 2'd0};
        end
      end
      WAIT: begin
        if (lat_last && req_rd_p0) begin
          mem_re   = 1'b1;
          mem_addr = {req_line_p0, 2'd0};
        end
      end
      BURST: begin
        pmem_resp = 1'b1;
        if (req_rd_p0) begin
          if (beat_cnt != 2'd3) begin
            mem_re   = 1'b1;
            mem_addr = {req_line_p0, beat_cnt + 2'd1};
          end
        end else begin
          mem_we   = !rst;
          mem_addr = {req_line_p0, beat_cnt};
        end
      end
      default: ;
    endcase
  end

  burst_mem_array #(
    .DEPTH_LINES(DEPTH_LINES)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .re   (mem_re),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(pmem_wdata),
    .rdata(pmem_rdata)
  );

`ifdef BURST_MEM_ADDR_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pmem_err <= 1'b0;
    end else begin
      pmem_err <= accept && ((|pmem_address[4:0]) || (pmem_read && pmem_write));
    end
  end
`endif

endmodule

// File: doc/burst_mem_responder.md
# burst_mem_responder

Synthesizable responder for the core's burst physical-memory port: it services the 4-beat, 64-bit line reads and writes the core's cache line adaptor issues on `pmem_*`. It sits on the far side of the core top's `pmem_read`, `pmem_write`, `pmem_address`, `pmem_wdata`, `pmem_rdata` and `pmem_resp` signals. It serves as a cycle-accurate backing memory with configurable access latency for standalone and FPGA bring-up.

## Interface
- `LATENCY`, default 10: idle cycles between request acceptance and the first data beat; 0 is legal.
- `DEPTH_LINES`, default 1024: number of 32-byte lines stored; must be a power of two.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `pmem_read`  in  1  line read request, held high until the transaction completes.
- `pmem_write`  in  1  line write request, held high until the transaction completes.
- `pmem_address`  in  32  byte address; bits [4:0] are ignored, so the address is line aligned.
- `pmem_wdata`  in  64  write beat, sampled in every cycle where `pmem_resp` is 1.
- `pmem_rdata`  out  64  read beat, valid in every cycle where `pmem_resp` is 1.
- `pmem_resp`  out  1  beat strobe, high for exactly 4 consecutive cycles per transaction.
- `pmem_err`  out  1  protocol-error pulse; present only with `BURST_MEM_ADDR_CHECK_EN`.

## Operation
- States:
  - IDLE: the block waits for a request.
  - WAIT: the latency counter runs.
  - BURST: `beat_cnt` counts 0 to 3.
  - DONE: one turnaround cycle.
- IDLE → WAIT when `pmem_read` or `pmem_write` is high. Latch the operation and `line_idx` on this edge.
  - `line_idx` is `pmem_address[5 +: log2(DEPTH_LINES)]`.
  - Higher address bits are ignored, so out-of-range addresses wrap modulo DEPTH_LINES.
  - If `LATENCY` is 0, go directly to BURST.
- If read and write are both high, read wins.
- WAIT → BURST when `lat_cnt` reaches `LATENCY`-1.
- BURST → DONE after beat 3.
- DONE → IDLE unconditionally.
  - Request level is ignored during DONE.
  - A request still high in the IDLE cycle after DONE starts a new transaction.
- Beat ordering: beat i carries line bytes [8i+7:8i]. Within each 64-bit beat, data is little-endian.
- Read: the word at (`line_idx`, i) is driven on `pmem_rdata` in beat-i cycle. The array read is issued one cycle ahead so that `pmem_rdata` is registered.
- Write: `pmem_wdata` is written to word (`line_idx`, i) at the end of beat-i cycle.
- The latched address and operation are fixed for the whole transaction. Changes on `pmem_address` or the request lines after acceptance are ignored.
- Once accepted, a transaction always runs to completion, even if the request drops early.
  - A dropped write still stores whatever `pmem_wdata` holds on each beat.
- Outputs outside beat cycles:
  - `pmem_resp` is 0.
  - `pmem_rdata` holds its last value.

## Timing
- Reset values:
  - state = IDLE
  - `pmem_resp` = 0
  - `pmem_rdata` = 0
  - `pmem_err` = 0
  - `lat_cnt` = 0
  - `beat_cnt` = 0
- Array contents are not reset.
- Reset mid-transaction aborts at once and returns to IDLE. Write beats committed before the reset remain; the rest are dropped.
- Cycle map for a request first high in cycle T:
  - `pmem_resp` is high in cycles T+1+L through T+4+L.
  - DONE is cycle T+5+L.
  - The earliest next acceptance is cycle T+6+L.
- Back-to-back throughput is one line per L+6 cycles.

## Configuration
- `BURST_MEM_ADDR_CHECK_EN` defined: adds the `pmem_err` output.
  - `pmem_err` is high for one cycle, the cycle after acceptance, if `pmem_address[4:0]` is nonzero or if read and write were both high at acceptance.
  - The transaction is still served with the aligned address, and read wins on conflict.
- `BURST_MEM_ADDR_CHECK_EN` undefined: no `pmem_err` port and no check logic. Servicing behaviour is identical.

## Structure
- Package `burst_mem_pkg` holds:
  - the state enum `bm_state_e` (IDLE, WAIT, BURST, DONE)
  - `BEATS` = 4, `BEAT_W` = 64, `LINE_BYTES` = 32
- Sub-module `burst_mem_array`: single-port synchronous RAM of `DEPTH_LINES*4` × 64 bits.
  - Addressed by {`line_idx`, `beat_idx`}.
  - One read or one write per cycle.
  - Registered read data.

## Test plan
- Reset, then idle 5 cycles → `pmem_resp`=0, `pmem_rdata`=0, state IDLE.
- Write line 0x100 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 (L=10), then read 0x100. Required:
  - write `pmem_resp` high in cycles T+11 through T+14;
  - read returns the same 4 beats in order in cycles T'+11 through T'+14.
- L=0, read request held across DONE:
  - `pmem_resp` high in T+1 through T+4, low in T+5 and T+6;
  - second burst in T+7 through T+10.
- Read and write both high at acceptance, address 0x104:
  - read of line 0x100 is served and the array is unchanged;
  - with the macro, `pmem_err`=1 in cycle T+1 only.
- Write of line 0x200 with `rst` asserted after beat 1:
  - beats 0–1 updated, beats 2–3 retain old data;
  - `pmem_resp`=0 on the next cycle and the block is in IDLE.
- Address 0x200 + DEPTH_LINES*32 with DEPTH_LINES=1024 → aliases line 0x200; a read returns line 0x200 data.
